// File: rtl/text_mmio_buffer.sv
// text_mmio_buffer
//   Memory-mapped, double-buffered character store feeding the VGA character
//   controller. The CPU writes a back buffer through a small register window.
//   The back buffer is copied to the front buffer on the falling edge of vsync.
//   If a hardware clear is running, the copy waits until the clear finishes, so
//   a frame never shows a torn or half-cleared line.
//
//   Ports
//     clock, reset   system clock; asynchronous active-high reset
//     write_data     CPU store data
//     data_adr       CPU byte address
//     mem_write      CPU store strobe (one cycle per store)
//     vsync_in       active-low VGA vsync, asynchronous to clock
//     read_data      STATUS = {16'h0, cursor, 7'h0, busy}, one-cycle latency
//     busy           clear engine running
//     char_flat      front buffer, bits [8i+7:8i] hold cell i
//
//   Register window (word offsets from BASE_ADDR)
//     0x000..0x0FC  DATA    word k holds cells 4k..4k+3, byte 0 is cell 4k
//     0x100         CTRL    bit0 = 1 starts a clear
//     0x104         PUTC    back[cursor] <= data[7:0], then cursor advances
//     0x108         CURSOR  set cursor; values past the last cell clamp to it
//     0x10C         STATUS  read-only
module text_mmio_buffer #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
   parameter int unsigned NUM_CHARS  = 41,
   parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [31:0]            write_data,
   input  logic [31:0]            data_adr,
   input  logic                   mem_write,
   input  logic                   vsync_in,
   output logic [31:0]            read_data,
   output logic                   busy,
   output logic [8*NUM_CHARS-1:0] char_flat
);

   localparam int unsigned CELL_W    = 8;
   localparam int unsigned CUR_W     = 8;
   localparam int unsigned FLAT_W    = CELL_W * NUM_CHARS;
   localparam int unsigned WORD_W    = 30;
   localparam logic [CUR_W-1:0] LAST_CELL = CUR_W'(NUM_CHARS - 1);

   localparam logic [WORD_W-1:0] CTRL_WORD   = WORD_W'(32'h100 >> 2);
   localparam logic [WORD_W-1:0] PUTC_WORD   = WORD_W'(32'h104 >> 2);
   localparam logic [WORD_W-1:0] CURSOR_WORD = WORD_W'(32'h108 >> 2);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic                clr_start;
   logic                clr_we;
   logic [CUR_W-1:0]    clr_idx;
   logic [CUR_W-1:0]    cursor;
   logic [FLAT_W-1:0]   back;

   logic                vs_meta;
   logic                vs_sync;
   logic                vs_prev;
   logic                vs_fall;
   logic                copy_pending;
   logic                copy_now;

   logic [WORD_W-1:0]   word;
   logic                data_we;
   logic                ctrl_we;
   logic                putc_we;
   logic                cursor_we;
   logic [CUR_W-1:0]    cursor_wr_val;

   // Word index relative to the window; byte-lane bits are not decoded.
   assign word = WORD_W'((data_adr - BASE_ADDR) >> 2);

   // Address decode; CPU buffer/cursor writes are locked out while clearing.
   always_comb begin
      data_we   = mem_write && !busy && (word < WORD_W'(64));
      ctrl_we   = mem_write && (word == CTRL_WORD);
      putc_we   = mem_write && !busy && (word == PUTC_WORD);
      cursor_we = mem_write && !busy && (word == CURSOR_WORD);
      cursor_wr_val = (write_data[7:0] > LAST_CELL) ? LAST_CELL : write_data[7:0];
   end

   // Clear FSM next-state logic.
   always_comb begin
      state_d   = state_q;
      clr_start = 1'b0;
      clr_we    = 1'b0;
      case (state_q)
         IDLE: begin
            if (ctrl_we && write_data[0]) begin
               state_d   = CLEAR;
               clr_start = 1'b1;
            end
         end
         CLEAR: begin
            clr_we = 1'b1;
            if (clr_idx == LAST_CELL) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Clear FSM state, index and busy flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         busy    <= 1'b0;
         clr_idx <= '0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d == CLEAR);
         if (clr_start) begin
            clr_idx <= '0;
         end else if (clr_we) begin
            clr_idx <= clr_idx + CUR_W'(1);
         end
      end
   end

   // Back buffer: clear engine, DATA word stores and PUTC are mutually exclusive.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         back <= {NUM_CHARS{CLEAR_CHAR}};
      end else begin
         for (int i = 0; i < int'(NUM_CHARS); i++) begin
            if (clr_we && (clr_idx == CUR_W'(i))) begin
               back[CELL_W*i +: CELL_W] <= CLEAR_CHAR;
            end else if (data_we && (word[5:0] == 6'(i / 4))) begin
               back[CELL_W*i +: CELL_W] <= write_data[CELL_W*(i % 4) +: CELL_W];
            end else if (putc_we && (cursor == CUR_W'(i))) begin
               back[CELL_W*i +: CELL_W] <= write_data[7:0];
            end
         end
      end
   end

   // Cursor: the clear engine homes it; PUTC advances with wrap.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cursor <= '0;
      end else if (clr_we) begin
         cursor <= '0;
      end else if (cursor_we) begin
         cursor <= cursor_wr_val;
      end else if (putc_we) begin
         cursor <= (cursor == LAST_CELL) ? '0 : cursor + CUR_W'(1);
      end
   end

   // vsync synchronizer and falling-edge detector; idle level is high.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vs_meta <= 1'b1;
         vs_sync <= 1'b1;
         vs_prev <= 1'b1;
      end else begin
         vs_meta <= vsync_in;
         vs_sync <= vs_meta;
         vs_prev <= vs_sync;
      end
   end

   assign vs_fall = vs_prev && !vs_sync;

   // A fresh edge copies at once when idle; otherwise it is held until busy drops.
   assign copy_now = (copy_pending || vs_fall) && !busy;

   // Front buffer copy and deferred-copy flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         copy_pending <= 1'b0;
         char_flat    <= {NUM_CHARS{CLEAR_CHAR}};
      end else begin
         copy_pending <= (copy_pending || vs_fall) && !copy_now;
         if (copy_now) begin
            char_flat <= back;
         end
      end
   end

   // STATUS register, refreshed every cycle regardless of address.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         read_data <= '0;
      end else begin
         read_data <= {16'h0, cursor, 7'h0, busy};
      end
   end

endmodule

// File: tb/tb_text_mmio_buffer.sv
// Bench for text_mmio_buffer: directed scenarios followed by random register
// traffic, all checked against a transaction-level model of the two buffers.
module tb_text_mmio_buffer;

   localparam logic [31:0] BASE = 32'h0000_0400;
   localparam int          N    = 41;
   localparam logic [7:0]  CLR  = 8'h20;

   logic             clock = 1'b0;
   logic             reset;
   logic [31:0]      write_data;
   logic [31:0]      data_adr;
   logic             mem_write;
   logic             vsync_in;
   logic [31:0]      read_data;
   logic             busy;
   logic [8*N-1:0]   char_flat;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: back/front cell arrays, cursor, busy flag.
   logic [7:0] mback  [N];
   logic [7:0] mfront [N];
   int         mcur;
   logic       mbusy;

   always #10 clock = ~clock;

   text_mmio_buffer #(
      .BASE_ADDR (BASE),
      .NUM_CHARS (N),
      .CLEAR_CHAR(CLR)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .write_data(write_data),
      .data_adr  (data_adr),
      .mem_write (mem_write),
      .vsync_in  (vsync_in),
      .read_data (read_data),
      .busy      (busy),
      .char_flat (char_flat)
   );

   function automatic logic [8*N-1:0] model_flat();
      logic [8*N-1:0] f;
      for (int i = 0; i < N; i++) f[8*i +: 8] = mfront[i];
      return f;
   endfunction

   function automatic logic [8*N-1:0] all_clear();
      logic [8*N-1:0] f;
      for (int i = 0; i < N; i++) f[8*i +: 8] = CLR;
      return f;
   endfunction

   function automatic logic [31:0] model_status();
      return {16'h0, 8'(mcur), 7'h0, mbusy};
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         mback[i]  = CLR;
         mfront[i] = CLR;
      end
      mcur  = 0;
      mbusy = 1'b0;
   endfunction

   // Applies one CPU store to the model; returns 1 when it starts a clear.
   function automatic bit model_write(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] w;
      w = (a - BASE) >> 2;
      if (mbusy) return 1'b0;
      if (w < 32'h40) begin
         for (int j = 0; j < 4; j++) begin
            int c;
            c = int'(w) * 4 + j;
            if (c < N) mback[c] = d[8*j +: 8];
         end
      end else if (w == 32'h40) begin
         if (d[0]) begin
            for (int i = 0; i < N; i++) mback[i] = CLR;
            mcur  = 0;
            mbusy = 1'b1;
            return 1'b1;
         end
      end else if (w == 32'h41) begin
         mback[mcur] = d[7:0];
         mcur = (mcur + 1) % N;
      end else if (w == 32'h42) begin
         mcur = (int'(d[7:0]) >= N) ? N - 1 : int'(d[7:0]);
      end
      return 1'b0;
   endfunction

   function automatic void model_copy();
      for (int i = 0; i < N; i++) mfront[i] = mback[i];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_flat(input string tag, input logic [8*N-1:0] exp);
      n_checks++;
      assert (char_flat === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, char_flat, exp);
      end
   endtask

   // One store cycle; called and returns at a falling clock edge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      data_adr   = a;
      write_data = d;
      mem_write  = 1'b1;
      @(negedge clock);
      mem_write  = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      void'(model_write(a, d));
      bus_write(a, d);
   endtask

   task automatic vsync_pulse();
      vsync_in = 1'b0;
      repeat (2) @(negedge clock);
      vsync_in = 1'b1;
      repeat (4) @(negedge clock);
      model_copy();
   endtask

   // Counts falling edges seen with busy high, bounded.
   task automatic wait_clear(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 200) begin
         cycles++;
         @(negedge clock);
      end
   endtask

   initial begin
      int lat, cyc, lag, n, m;
      bit held;
      logic [8*N-1:0] prev, oldf;
      logic [31:0] a, d;

      reset      = 1'b1;
      mem_write  = 1'b0;
      vsync_in   = 1'b1;
      write_data = '0;
      data_adr   = '0;
      model_reset();

      // Reset state
      @(negedge clock);
      check("rst_read_data", read_data, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check_flat("rst_char_flat", all_clear());
      reset = 1'b0;
      @(negedge clock);
      check("post_rst_status", read_data, model_status());

      // DATA word store, no vsync: front untouched
      store(BASE + 32'h000, 32'h4443_4241);
      repeat (5) @(negedge clock);
      check_flat("no_vsync_unchanged", model_flat());

      // vsync falling edge: copy latency and contents
      prev = model_flat();
      vsync_in = 1'b0;
      lat = 0;
      while (char_flat === prev && lat < 10) begin
         @(negedge clock);
         lat++;
      end
      check("vsync_latency_3_or_4", 32'(lat >= 3 && lat <= 4), 32'd1);
      vsync_in = 1'b1;
      repeat (3) @(negedge clock);
      model_copy();
      check_flat("abcd_copy", model_flat());
      check("cell0_A", 32'(char_flat[7:0]), 32'h41);
      check("cell3_D", 32'(char_flat[31:24]), 32'h44);

      // Cursor wrap through PUTC
      store(BASE + 32'h108, 32'd40);
      store(BASE + 32'h104, 32'h5A);
      store(BASE + 32'h104, 32'h31);
      @(negedge clock);
      check("putc_wrap_status", read_data, model_status());
      check("putc_wrap_cursor", 32'(read_data[15:8]), 32'd1);
      vsync_pulse();
      check_flat("putc_copy", model_flat());
      check("cell40_5A", 32'(char_flat[8*40 +: 8]), 32'h5A);
      check("cell0_31", 32'(char_flat[7:0]), 32'h31);

      // Cursor clamp
      store(BASE + 32'h108, 32'd200);
      @(negedge clock);
      check("cursor_clamp", read_data, model_status());

      // Clear with ignored writes while busy
      void'(model_write(BASE + 32'h100, 32'h1));
      bus_write(BASE + 32'h100, 32'h1);
      check("busy_after_ctrl", 32'(busy), 32'h1);
      n = 0;
      if (busy) n++;
      store(BASE + 32'h000, 32'h1122_3344);
      if (busy) n++;
      store(BASE + 32'h100, 32'h1);
      if (busy) n++;
      store(BASE + 32'h104, 32'h77);
      if (busy) n++;
      store(BASE + 32'h108, 32'd9);
      wait_clear(m);
      check("clear_busy_cycles", 32'(n + m), 32'd41);
      mbusy = 1'b0;
      @(negedge clock);
      check("status_after_clear", read_data, model_status());
      vsync_pulse();
      check_flat("clear_copy", model_flat());
      check("cell0_after_clear", 32'(char_flat[7:0]), 32'h20);

      // vsync during clear: front holds until clear completes
      for (int k = 0; k < 11; k++) begin
         store(BASE + 32'(4 * k), ($urandom & 32'h7f7f_7f7f) | 32'h8080_8080);
      end
      vsync_pulse();
      check_flat("preload_copy", model_flat());
      oldf = model_flat();
      void'(model_write(BASE + 32'h100, 32'h1));
      bus_write(BASE + 32'h100, 32'h1);
      cyc  = 0;
      held = 1'b1;
      while (busy === 1'b1 && cyc < 200) begin
         if (cyc == 9)  vsync_in = 1'b0;
         if (cyc == 13) vsync_in = 1'b1;
         if (char_flat !== oldf) held = 1'b0;
         cyc++;
         @(negedge clock);
      end
      check("hold_during_clear", 32'(held), 32'd1);
      check("clear2_busy_cycles", 32'(cyc), 32'd41);
      mbusy = 1'b0;
      model_copy();
      lag = 0;
      while (char_flat === oldf && lag < 5) begin
         lag++;
         @(negedge clock);
      end
      check("deferred_copy_lag", 32'(lag <= 2), 32'd1);
      check_flat("deferred_copy_all_clear", all_clear());

      // Partially out-of-range DATA word
      store(BASE + 32'h028, 32'h0000_0078);
      vsync_pulse();
      check_flat("partial_word", model_flat());
      check("cell40_78", 32'(char_flat[8*40 +: 8]), 32'h78);

      // Random register traffic
      for (int it = 0; it < 150; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: store(BASE + 32'(4 * $urandom_range(0, 15)), $urandom);
            4, 5:       store(BASE + 32'h104, $urandom);
            6:          store(BASE + 32'h108, 32'($urandom_range(0, 80)));
            7: begin
               if ($urandom_range(0, 1) == 0) a = BASE + 32'h10C + 32'(4 * $urandom_range(0, 60));
               else                           a = BASE - 32'(4 * $urandom_range(1, 16));
               store(a, $urandom);
            end
            8: begin
               vsync_pulse();
               check_flat("rand_copy", model_flat());
            end
            default: begin
               d = $urandom;
               if (model_write(BASE + 32'h100, d)) begin
                  bus_write(BASE + 32'h100, d);
                  wait_clear(m);
                  check("rand_clear_cycles", 32'(m), 32'd41);
                  mbusy = 1'b0;
               end else begin
                  bus_write(BASE + 32'h100, d);
               end
            end
         endcase
         @(negedge clock);
         check("rand_status", read_data, model_status());
      end
      vsync_pulse();
      check_flat("final_copy", model_flat());

      // Reset in the middle of a clear
      void'(model_write(BASE + 32'h100, 32'h1));
      bus_write(BASE + 32'h100, 32'h1);
      repeat (5) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check("midclear_rst_busy", 32'(busy), 32'h0);
      check("midclear_rst_read_data", read_data, 32'h0);
      check_flat("midclear_rst_flat", all_clear());
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("midclear_post_status", read_data, model_status());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
